// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
// Default channel width, NOP bubble encoding, occupancy codes, channel indices.
package mips_pipe_pkg;

    localparam int          DEF_WIDTH       = 32;
    localparam logic [31:0] DEF_BUBBLE_WORD = 32'h0000_0000;  // sll $0,$0,0

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int CH_INSTR = 0;
    localparam int CH_PC4   = 1;

    // The controller state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } occ_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle of one elastic pipeline stage register.
// stall_cnt exists only when PIPE_STALL_COUNT_EN is defined.
interface pipe_stage_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
`ifdef PIPE_STALL_COUNT_EN
    ,
    parameter int CNT_W  = 32
`endif
);

    // Handshake: a word moves on a rising edge where valid & ready are both 1.
    // The sender holds valid and data stable until taken; ready never depends
    // combinationally on valid.
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_CH*WIDTH-1:0]   out_data;
    logic [1:0]                occupancy;
`ifdef PIPE_STALL_COUNT_EN
    logic [CNT_W-1:0]          stall_cnt;
`endif

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
`ifdef PIPE_STALL_COUNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
`ifdef PIPE_STALL_COUNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/pipe_skid_ctrl.sv
// Valid/ready/occupancy controller for the one-entry skid pipeline register.
// Produces registered in_ready/out_valid and the data-register load strobes.
module pipe_skid_ctrl
    import mips_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_in_valid,
    input  logic       i_out_ready,
    input  logic       i_flush,
    output logic       o_in_ready,
    output logic       o_out_valid,
    output logic [1:0] o_occupancy,
    output logic       o_load_main_in,
    output logic       o_load_main_skid,
    output logic       o_load_skid
);

    occ_state_e r_state;
    occ_state_e w_next;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       w_accept;
    logic       w_drain;

    assign w_accept = i_in_valid & r_in_ready;
    assign w_drain  = r_out_valid & i_out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != ST_FULL);
            r_out_valid <= (w_next != ST_EMPTY);
        end
    end

    always_comb begin
        w_next           = r_state;
        o_load_main_in   = 1'b0;
        o_load_main_skid = 1'b0;
        o_load_skid      = 1'b0;
        if (i_flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next         = ST_ONE;
                        o_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        o_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next      = ST_FULL;
                        o_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can move the state.
                    if (w_drain) begin
                        w_next           = ST_ONE;
                        o_load_main_skid = 1'b1;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_occupancy = r_state;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic NUM_CH x WIDTH pipeline register with one-entry skid buffer and flush.
// Optional saturating stall counter enabled by PIPE_STALL_COUNT_EN.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               NUM_CH      = 2,
    parameter logic [WIDTH-1:0] BUBBLE_WORD = WIDTH'(DEF_BUBBLE_WORD)
`ifdef PIPE_STALL_COUNT_EN
    ,
    parameter int               CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus
);

    localparam int              DW         = NUM_CH * WIDTH;
    localparam logic [DW-1:0]   BUBBLE_VEC = {NUM_CH{BUBBLE_WORD}};

    logic [DW-1:0] r_main_d;
    logic [DW-1:0] r_skid_d;
    logic          w_in_ready;
    logic          w_out_valid;
    logic [1:0]    w_occupancy;
    logic          w_load_main_in;
    logic          w_load_main_skid;
    logic          w_load_skid;

    pipe_skid_ctrl u_ctrl (
        .clk              (clk),
        .reset            (reset),
        .i_in_valid       (bus.in_valid),
        .i_out_ready      (bus.out_ready),
        .i_flush          (bus.flush),
        .o_in_ready       (w_in_ready),
        .o_out_valid      (w_out_valid),
        .o_occupancy      (w_occupancy),
        .o_load_main_in   (w_load_main_in),
        .o_load_main_skid (w_load_main_skid),
        .o_load_skid      (w_load_skid)
    );

    // Flush overrides any load so both registers show the bubble afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_d <= BUBBLE_VEC;
            r_skid_d <= BUBBLE_VEC;
        end else if (bus.flush) begin
            r_main_d <= BUBBLE_VEC;
            r_skid_d <= BUBBLE_VEC;
        end else begin
            if (w_load_main_in) begin
                r_main_d <= bus.in_data;
            end else if (w_load_main_skid) begin
                r_main_d <= r_skid_d;
            end
            if (w_load_skid) begin
                r_skid_d <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_d;
    assign bus.occupancy = w_occupancy;

`ifdef PIPE_STALL_COUNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Counts edges where downstream refuses a valid word; survives flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg with a queue-based reference.
// Stall counter checks are active when PIPE_STALL_COUNT_EN is defined.
module tb_pipe_stage_reg;
    import mips_pipe_pkg::*;

    localparam int            WIDTH  = 32;
    localparam int            NUM_CH = 2;
    localparam int            DW     = WIDTH * NUM_CH;
    localparam logic [DW-1:0] BUBBLE = '0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = BUBBLE;
    int unsigned   stall_model = 0;

    always #5 clk = ~clk;

`ifdef PIPE_STALL_COUNT_EN
    pipe_stage_reg_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(32)) bus ();
    pipe_stage_reg #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .BUBBLE_WORD(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`else
    pipe_stage_reg_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();
    pipe_stage_reg #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .BUBBLE_WORD(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack(input logic [31:0] instr, input logic [31:0] pc4);
        logic [DW-1:0] w;
        w = '0;
        w[CH_INSTR*WIDTH +: WIDTH] = instr;
        w[CH_PC4*WIDTH +: WIDTH]   = pc4;
        return w;
    endfunction

    // Scoreboard: checks the visible state against a two-deep FIFO model,
    // pops on every DUT drain and pushes every word the model says is taken.
    always @(negedge clk) begin
        int            pre;
        logic [DW-1:0] w;
        if (!reset) begin
            exp_q.delete();
            last_out    = BUBBLE;
            stall_model = 0;
            check("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check("rst_in_ready", 64'(bus.in_ready), 64'(1));
            check("rst_occupancy", 64'(bus.occupancy), 64'(0));
            check("rst_out_data", 64'(bus.out_data), 64'(BUBBLE));
`ifdef PIPE_STALL_COUNT_EN
            check("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
`endif
        end else begin
            pre = exp_q.size();
            check("occupancy", 64'(bus.occupancy), 64'(pre));
            check("in_ready", 64'(bus.in_ready), 64'(pre < 2));
            check("out_valid", 64'(bus.out_valid), 64'(pre > 0));
            check("out_data", 64'(bus.out_data), 64'((pre > 0) ? exp_q[0] : last_out));
`ifdef PIPE_STALL_COUNT_EN
            check("stall_cnt", 64'(bus.stall_cnt), 64'(stall_model));
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (pre == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drain_unexpected: got %h expected no word at %0t", bus.out_data, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("drain_order", 64'(bus.out_data), 64'(w));
                    last_out = w;
                end
            end
            if ((pre > 0) && !bus.out_ready && (stall_model != 32'hFFFF_FFFF)) stall_model++;
            if (bus.flush) begin
                exp_q.delete();
                last_out = BUBBLE;
            end else if (bus.in_valid && (pre < 2)) begin
                exp_q.push_back(bus.in_data);
            end
        end
    end

    task automatic idle_cycles(input int n);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
    endtask

    // Called #1 after an edge with a word offered; returns #1 after the taking edge.
    task automatic wait_accept(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no accept expected accept within 20 cycles", name);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] w, input string name);
        offer(w);
        wait_accept(name);
    endtask

    initial begin
        logic [DW-1:0] wa, wb, wc, wd;
        bit            pend;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held, then released with no stimulus.
        repeat (3) @(posedge clk);
        #1;
        check("reset_occ", 64'(bus.occupancy), 64'(OCC_EMPTY));
        check("reset_data", 64'(bus.out_data), 64'h0);
        reset = 1'b1;
        idle_cycles(3);
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
        check("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // Streaming with the downstream always ready.
        bus.out_ready = 1'b1;
        wa = pack(32'h2008_0005, 32'h0000_3004);
        wb = pack(32'h0109_5020, 32'h0000_3008);
        send(wa, "stream_a");
        check("stream_a_data", 64'(bus.out_data), 64'(wa));
        check("stream_a_occ", 64'(bus.occupancy), 64'(OCC_ONE));
        send(wb, "stream_b");
        check("stream_b_data", 64'(bus.out_data), 64'(wb));
        check("stream_b_occ", 64'(bus.occupancy), 64'(OCC_ONE));
        idle_cycles(3);

        // Backpressure: A in main, B in skid, C refused until the stage drains.
        bus.out_ready = 1'b0;
        wa = pack(32'h8C08_0000, 32'h0000_4004);
        wb = pack(32'hAC09_0004, 32'h0000_4008);
        wc = pack(32'h1000_FFFF, 32'h0000_400C);
        send(wa, "bp_a");
        send(wb, "bp_b");
        offer(wc);
        repeat (3) @(posedge clk);
        #1;
        check("bp_occ", 64'(bus.occupancy), 64'(OCC_FULL));
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        check("bp_head", 64'(bus.out_data), 64'(wa));
        bus.out_ready = 1'b1;
        wait_accept("bp_c");
        idle_cycles(4);
        check("bp_drained_occ", 64'(bus.occupancy), 64'(OCC_EMPTY));

        // Flush while full with a word offered in the flush cycle.
        bus.out_ready = 1'b0;
        send(pack(32'h0000_0001, 32'h0000_5004), "fl_a");
        send(pack(32'h0000_0002, 32'h0000_5008), "fl_b");
        wd = pack(32'h0000_0003, 32'h0000_500C);
        offer(wd);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_occ", 64'(bus.occupancy), 64'(OCC_EMPTY));
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_out_data", 64'(bus.out_data), 64'(BUBBLE));
        check("flush_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        idle_cycles(3);

        // Asynchronous reset between edges while full.
        bus.out_ready = 1'b0;
        send(pack(32'h0000_0011, 32'h0000_6004), "mr_a");
        send(pack(32'h0000_0012, 32'h0000_6008), "mr_b");
        check("mr_full", 64'(bus.occupancy), 64'(OCC_FULL));
        #2;
        reset = 1'b0;
        #1;
        check("mr_out_valid", 64'(bus.out_valid), 64'(0));
        check("mr_occ", 64'(bus.occupancy), 64'(OCC_EMPTY));
        check("mr_in_ready", 64'(bus.in_ready), 64'(1));
        check("mr_out_data", 64'(bus.out_data), 64'(BUBBLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(1);

`ifdef PIPE_STALL_COUNT_EN
        // Seven refused edges, then a flush that drains without stalling.
        bus.out_ready = 1'b0;
        send(pack(32'h0000_0021, 32'h0000_7004), "st_a");
        repeat (7) @(posedge clk);
        #1;
        check("stall_7", 64'(bus.stall_cnt), 64'(7));
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("stall_after_flush", 64'(bus.stall_cnt), 64'(7));
        idle_cycles(2);
`endif

        // Randomized traffic; an offered word is held until taken or flushed.
        pend = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                offer({$urandom, $urandom});
                pend = 1'b1;
            end
            @(negedge clk);
            if (bus.in_ready || bus.flush) pend = 1'b0;
            @(posedge clk);
            #1;
            if (!pend) bus.in_valid = 1'b0;
        end

        bus.out_ready = 1'b1;
        idle_cycles(5);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
